uart_boot_ctrl: RTL

- Host-driven boot and run controller for the core.
- Parses a framed byte protocol from the UART receiver, packs payload bytes into 32-bit words, and drives the core's instruction/data memory write ports.
- Sequences the core `run` signal and returns a one-byte status over the UART transmitter.
- Replaces switch-based load/run selection at the board top level.

---
 rtl/uart_boot_pkg.sv | 35 +++
 rtl/uart_boot_ctrl_word_packer.sv | 35 +++
 rtl/uart_boot_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot controller.
//   boot_state_t       : controller FSM states (CKSUM only with BOOT_CKSUM_EN)
//   CMD_*              : frame command bytes
//   ST_OK / ST_ERR     : status bytes returned to the host
//   word_addr()        : byte address of payload word idx relative to base
// Configuration macro: BOOT_CKSUM_EN (adds the trailing-checksum state).
package uart_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_ADDR,
        HDR_LEN,
        PAYLOAD,
`ifdef BOOT_CKSUM_EN
        CKSUM,
`endif
        ACK,
        RUN_WAIT
    } boot_state_t;

    localparam logic [7:0] CMD_INSN = 8'h49;  // 'I'
    localparam logic [7:0] CMD_DATA = 8'h44;  // 'D'
    localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_STOP = 8'h53;  // 'S'

    localparam logic [7:0] ST_OK  = 8'h4B;    // 'K'
    localparam logic [7:0] ST_ERR = 8'h45;    // 'E'

    // Address arithmetic wraps at 32 bits by construction.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/uart_boot_ctrl_word_packer.sv
// boot_word_packer: assembles big-endian 32-bit words from a byte stream.
//   clk, reset    : system clock, synchronous active-high reset
//   clear_i       : restart at byte 0 of a word (held while not in payload)
//   byte_valid_i  : byte_i is a payload byte this cycle
//   byte_i        : payload byte
//   word_o        : completed word, valid while word_done_o is high
//   word_done_o   : high on the cycle the 4th byte of a word arrives
module boot_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    // Only the first three bytes need storage; the fourth is taken live.
    logic [23:0] buf_q;
    logic [1:0]  idx_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            buf_q <= '0;
            idx_q <= '0;
        end else if (byte_valid_i) begin
            buf_q <= {buf_q[15:0], byte_i};
            idx_q <= idx_q + 2'd1;
        end
    end

    assign word_o      = {buf_q, byte_i};
    assign word_done_o = byte_valid_i && (idx_q == 2'd3);

endmodule

// File: rtl/uart_boot_ctrl.sv
// uart_boot_ctrl: host-driven boot/run controller.
// Parses framed commands from the UART receiver, writes payload words into
// instruction or data memory, sequences the core run enable and returns a
// one-byte status ('K' ok / 'E' error) over the UART transmitter.
// Ports:
//   clk, reset               : system clock, synchronous active-high reset
//   rx_valid, rx_data        : received byte strobe and value
//   tx_ready                 : transmitter accepts tx_data this cycle
//   tx_valid, tx_data        : status byte offer, held until accepted
//   insn_addr/din/we         : instruction memory write port
//   data_addr/din/we         : data memory write port
//   run                      : core run enable
//   busy                     : controller not idle
//   overrun                  : sticky flag, byte dropped in ACK/RUN_WAIT
// Parameters: RUN_DELAY (cycles from 'R' to run), TIMEOUT (0 disables).
// Configuration macro: BOOT_CKSUM_EN (trailing XOR checksum byte per frame).
module uart_boot_ctrl
    import uart_boot_pkg::*;
#(
    parameter int unsigned RUN_DELAY = 100,
    parameter int unsigned TIMEOUT   = 10_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic [31:0] insn_addr,
    output logic [31:0] insn_din,
    output logic        insn_we,
    output logic [31:0] data_addr,
    output logic [31:0] data_din,
    output logic        data_we,
    output logic        run,
    output logic        busy,
    output logic        overrun
);

    localparam logic [31:0] RUN_DELAY_W = 32'(RUN_DELAY);
    localparam logic [31:0] TIMEOUT_W   = 32'(TIMEOUT);

    boot_state_t state_q, state_d;
    logic        tgt_insn_q, tgt_insn_d;
    logic [31:0] base_q, base_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  hdr_idx_q, hdr_idx_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [7:0]  status_q, status_d;
    logic        run_q, run_d;
    logic        overrun_q, overrun_d;
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic [31:0] run_cnt_q, run_cnt_d;
    logic [31:0] insn_addr_q, insn_addr_d, insn_din_q, insn_din_d;
    logic [31:0] data_addr_q, data_addr_d, data_din_q, data_din_d;
    logic        insn_we_q, insn_we_d, data_we_q, data_we_d;
`ifdef BOOT_CKSUM_EN
    logic [7:0]  cksum_q, cksum_d;
`endif

    logic        in_frame;
    logic        frame_end;
    logic        pk_valid, pk_done;
    logic [31:0] pk_word;
    logic [15:0] len_next;

    assign pk_valid = rx_valid && (state_q == PAYLOAD);
    assign len_next = {len_q[7:0], rx_data};

    boot_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (state_q != PAYLOAD),
        .byte_valid_i (pk_valid),
        .byte_i       (rx_data),
        .word_o       (pk_word),
        .word_done_o  (pk_done)
    );

    // States in which the inter-byte timeout is armed.
    always_comb begin
        in_frame = 1'b0;
        case (state_q)
            HDR_ADDR, HDR_LEN, PAYLOAD: in_frame = 1'b1;
`ifdef BOOT_CKSUM_EN
            CKSUM:                      in_frame = 1'b1;
`endif
            default:                    in_frame = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        tgt_insn_d  = tgt_insn_q;
        base_d      = base_q;
        len_d       = len_q;
        hdr_idx_d   = hdr_idx_q;
        word_idx_d  = word_idx_q;
        status_d    = status_q;
        run_d       = run_q;
        overrun_d   = overrun_q;
        idle_cnt_d  = '0;
        run_cnt_d   = run_cnt_q;
        insn_addr_d = insn_addr_q;
        insn_din_d  = insn_din_q;
        data_addr_d = data_addr_q;
        data_din_d  = data_din_q;
        insn_we_d   = 1'b0;
        data_we_d   = 1'b0;
        frame_end   = 1'b0;
`ifdef BOOT_CKSUM_EN
        cksum_d     = cksum_q;
`endif

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    hdr_idx_d = '0;
                    case (rx_data)
                        CMD_INSN, CMD_DATA: begin
                            tgt_insn_d = (rx_data == CMD_INSN);
                            run_d      = 1'b0;
                            state_d    = HDR_ADDR;
                        end
                        CMD_RUN: begin
                            run_cnt_d = '0;
                            if (RUN_DELAY_W == '0) run_d = 1'b1;
                            state_d   = RUN_WAIT;
                        end
                        CMD_STOP: begin
                            run_d    = 1'b0;
                            status_d = ST_OK;
                            state_d  = ACK;
                        end
                        default: begin
                            status_d = ST_ERR;
                            state_d  = ACK;
                        end
                    endcase
                end
            end
            HDR_ADDR: begin
                if (rx_valid) begin
                    base_d    = {base_q[23:0], rx_data};
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    if (hdr_idx_q == 2'd3) begin
                        hdr_idx_d = '0;
                        state_d   = HDR_LEN;
                    end
                end
            end
            HDR_LEN: begin
                if (rx_valid) begin
                    len_d = len_next;
                    if (hdr_idx_q == 2'd0) begin
                        hdr_idx_d = 2'd1;
                    end else begin
                        hdr_idx_d  = '0;
                        word_idx_d = '0;
                        if (len_next == '0) frame_end = 1'b1;
                        else                state_d   = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (pk_done) begin
                    if (tgt_insn_q) begin
                        insn_we_d   = 1'b1;
                        insn_addr_d = word_addr(base_q, word_idx_q);
                        insn_din_d  = pk_word;
                    end else begin
                        data_we_d   = 1'b1;
                        data_addr_d = word_addr(base_q, word_idx_q);
                        data_din_d  = pk_word;
                    end
                    word_idx_d = word_idx_q + 16'd1;
                    if (word_idx_q == len_q - 16'd1) frame_end = 1'b1;
                end
            end
`ifdef BOOT_CKSUM_EN
            CKSUM: begin
                if (rx_valid) begin
                    status_d = (rx_data == cksum_q) ? ST_OK : ST_ERR;
                    state_d  = ACK;
                end
            end
`endif
            ACK: begin
                if (tx_ready) state_d = IDLE;
            end
            RUN_WAIT: begin
                // run rises on the last counted cycle; the status follows one
                // cycle later so the host sees 'K' only once run is visible.
                if (run_cnt_q != RUN_DELAY_W) begin
                    run_cnt_d = run_cnt_q + 32'd1;
                    if (run_cnt_q == RUN_DELAY_W - 32'd1) run_d = 1'b1;
                end else begin
                    status_d = ST_OK;
                    state_d  = ACK;
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_end) begin
`ifdef BOOT_CKSUM_EN
            state_d = CKSUM;
`else
            status_d = ST_OK;
            state_d  = ACK;
`endif
        end

`ifdef BOOT_CKSUM_EN
        if (state_q == IDLE)
            cksum_d = '0;
        else if (rx_valid && (state_q == HDR_ADDR || state_q == HDR_LEN || state_q == PAYLOAD))
            cksum_d = cksum_q ^ rx_data;
`endif

        // Silent cycles inside a frame; any received byte restarts the count.
        if (in_frame && !rx_valid) begin
            idle_cnt_d = idle_cnt_q + 32'd1;
            if (TIMEOUT_W != '0 && idle_cnt_q == TIMEOUT_W - 32'd1) begin
                status_d = ST_ERR;
                state_d  = ACK;
            end
        end

        if (rx_valid && (state_q == ACK || state_q == RUN_WAIT)) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tgt_insn_q  <= 1'b0;
            base_q      <= '0;
            len_q       <= '0;
            hdr_idx_q   <= '0;
            word_idx_q  <= '0;
            status_q    <= '0;
            run_q       <= 1'b0;
            overrun_q   <= 1'b0;
            idle_cnt_q  <= '0;
            run_cnt_q   <= '0;
            insn_addr_q <= '0;
            insn_din_q  <= '0;
            data_addr_q <= '0;
            data_din_q  <= '0;
            insn_we_q   <= 1'b0;
            data_we_q   <= 1'b0;
`ifdef BOOT_CKSUM_EN
            cksum_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tgt_insn_q  <= tgt_insn_d;
            base_q      <= base_d;
            len_q       <= len_d;
            hdr_idx_q   <= hdr_idx_d;
            word_idx_q  <= word_idx_d;
            status_q    <= status_d;
            run_q       <= run_d;
            overrun_q   <= overrun_d;
            idle_cnt_q  <= idle_cnt_d;
            run_cnt_q   <= run_cnt_d;
            insn_addr_q <= insn_addr_d;
            insn_din_q  <= insn_din_d;
            data_addr_q <= data_addr_d;
            data_din_q  <= data_din_d;
            insn_we_q   <= insn_we_d;
            data_we_q   <= data_we_d;
`ifdef BOOT_CKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

    assign tx_valid  = (state_q == ACK);
    assign tx_data   = status_q;
    assign insn_addr = insn_addr_q;
    assign insn_din  = insn_din_q;
    assign insn_we   = insn_we_q;
    assign data_addr = data_addr_q;
    assign data_din  = data_din_q;
    assign data_we   = data_we_q;
    assign run       = run_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule
